// File: rtl/slc3_mmio_bridge.sv
// SLC-3 MAR/MDR <-> SRAM bridge with IO decode for switches, hex and LEDs (SW_ADDR, LED_ADDR).
// Latency: SRAM_WAIT+2 edges for SRAM, 2 for IO; busy holds off new requests. Optional: SLC3_SW_DEBOUNCE_EN.
module slc3_mmio_bridge #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                SW_W      = 10,
  parameter int                LED_W     = 10,
  parameter int                NUM_HEX   = 4,
  parameter int                SRAM_WAIT = 1,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 16'hFFFF,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 16'hFFFE,
  parameter logic [15:0]       DB_CYC    = 16'd5000
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [DATA_W-1:0]    wdata,
  output logic [DATA_W-1:0]    rdata,
  output logic                 ack,
  output logic                 busy,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [DATA_W-1:0]    sram_wdata,
  input  logic [DATA_W-1:0]    sram_rdata,
  output logic                 OE_n,
  output logic                 WE_n,
  input  logic [SW_W-1:0]      sw,
  output logic [4*NUM_HEX-1:0] hex_nib,
  output logic [LED_W-1:0]     led
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] WAIT_L = 4'(SRAM_WAIT);

  state_t            state, state_n;
  logic [3:0]        wcnt;
  logic              we_q, io_q, last;
  logic [SW_W-1:0]   sw_s1, sw_s2, sw_val;
  logic [DATA_W-1:0] io_rdata;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

`ifdef SLC3_SW_DEBOUNCE_EN
  logic [15:0]     db_cnt [SW_W];
  logic [SW_W-1:0] sw_db;

  // A bit flips only after its synced value has disagreed for DB_CYC straight cycles.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sw_db <= '0;
      for (int i = 0; i < SW_W; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < SW_W; i++) begin
        if (sw_s2[i] == sw_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_CYC - 16'd1) begin
          sw_db[i]  <= sw_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign sw_val = sw_db;
`else
  assign sw_val = sw_s2;
`endif

  assign io_rdata = (sram_addr == SW_ADDR) ? DATA_W'(sw_val) : DATA_W'(led);

  // Strobes decode straight from state flops so reset pulls them high without an edge.
  always_comb begin
    state_n = state;
    ack     = 1'b0;
    busy    = 1'b0;
    OE_n    = 1'b1;
    WE_n    = 1'b1;
    last    = 1'b0;
    case (state)
      IDLE: if (req) state_n = ACCESS;
      ACCESS: begin
        busy = 1'b1;
        OE_n = we_q | io_q;
        WE_n = ~we_q | io_q;
        last = io_q | (wcnt == WAIT_L);
        if (last) state_n = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        ack     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      wcnt       <= '0;
      we_q       <= 1'b0;
      io_q       <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      rdata      <= '0;
      hex_nib    <= '0;
      led        <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req) begin
        sram_addr  <= addr;
        sram_wdata <= wdata;
        we_q       <= we;
        io_q       <= (addr == SW_ADDR) || (addr == LED_ADDR);
        wcnt       <= '0;
      end
      if (state == ACCESS) begin
        if (!last) begin
          wcnt <= wcnt + 4'd1;
        end else if (!we_q) begin
          rdata <= io_q ? io_rdata : sram_rdata;
        end else if (io_q) begin
          if (sram_addr == SW_ADDR) hex_nib <= sram_wdata[4*NUM_HEX-1:0];
          else                      led     <= sram_wdata[LED_W-1:0];
        end
      end
    end
  end

endmodule
